// File: rtl/poly_tone_gen.sv
// Polyphonic game tone generator: NUM_VOICES independent square/sawtooth voices,
// mixed with saturation into a registered DAC code.
module poly_tone_gen #(
  parameter int DAC_W      = 7,
  parameter int NUM_VOICES = 2,
  parameter int PER_W      = 9,
  parameter int DUR_W      = 16
) (
  input  logic                        clk,
  input  logic                        nRst,
  input  logic [NUM_VOICES-1:0]       trig,
  input  logic [NUM_VOICES*PER_W-1:0] period,
  input  logic [NUM_VOICES*DUR_W-1:0] duration,
  input  logic [NUM_VOICES-1:0]       wave_sel,
  input  logic                        mute,
  output logic [NUM_VOICES-1:0]       busy,
  output logic [NUM_VOICES-1:0]       done,
  output logic [DAC_W-1:0]            dacCount
);

  localparam int SUM_W = DAC_W + $clog2(NUM_VOICES) + 1;
  localparam logic [DAC_W-1:0] FULL_SCALE = '1;

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} voice_state_t;

  logic [DAC_W-1:0] sample [NUM_VOICES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      voice_state_t     state_reg, state_next;
      logic [PER_W-1:0] per_reg, per_next;
      logic [PER_W-1:0] phase_reg, phase_next;
      logic [DUR_W-1:0] remaining_reg, remaining_next;
      logic             wave_reg, wave_next;
      logic             level_reg, level_next;
      logic [DAC_W-1:0] ramp_reg, ramp_next;
      logic             done_reg, done_next;
      logic [PER_W-1:0] per_in;
      logic [DUR_W-1:0] dur_in;
      logic             valid_trig;
      logic             tick;

      assign per_in     = period[gi*PER_W +: PER_W];
      assign dur_in     = duration[gi*DUR_W +: DUR_W];
      assign valid_trig = trig[gi] && (per_in != '0) && (dur_in != '0);
      assign tick       = (phase_reg == per_reg - PER_W'(1));

      always_ff @(posedge clk or posedge nRst) begin
        if (nRst) begin
          state_reg     <= IDLE;
          per_reg       <= '0;
          phase_reg     <= '0;
          remaining_reg <= '0;
          wave_reg      <= 1'b0;
          level_reg     <= 1'b0;
          ramp_reg      <= '0;
          done_reg      <= 1'b0;
        end else begin
          state_reg     <= state_next;
          per_reg       <= per_next;
          phase_reg     <= phase_next;
          remaining_reg <= remaining_next;
          wave_reg      <= wave_next;
          level_reg     <= level_next;
          ramp_reg      <= ramp_next;
          done_reg      <= done_next;
        end
      end

      always_comb begin
        state_next     = state_reg;
        per_next       = per_reg;
        phase_next     = phase_reg;
        remaining_next = remaining_reg;
        wave_next      = wave_reg;
        level_next     = level_reg;
        ramp_next      = ramp_reg;
        done_next      = 1'b0;
        if (valid_trig) begin
          // A valid trigger (re)starts the note from either state.
          state_next     = PLAY;
          per_next       = per_in;
          remaining_next = dur_in;
          wave_next      = wave_sel[gi];
          phase_next     = '0;
          level_next     = 1'b1;
          ramp_next      = '0;
        end else if (state_reg == PLAY) begin
          if (remaining_reg == DUR_W'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            remaining_next = remaining_reg - DUR_W'(1);
          end
          // Both waveforms advance together; the sample mux picks one.
          if (tick) begin
            phase_next = '0;
            level_next = ~level_reg;
            ramp_next  = ramp_reg + DAC_W'(1);
          end else begin
            phase_next = phase_reg + PER_W'(1);
          end
        end
      end

      assign busy[gi]   = (state_reg == PLAY);
      assign done[gi]   = done_reg;
      assign sample[gi] = (state_reg != PLAY) ? '0 :
                          (wave_reg ? ramp_reg : {DAC_W{level_reg}});
    end
  endgenerate

  logic [SUM_W-1:0] mix_sum;
  logic [DAC_W-1:0] mix_sat;
  logic [DAC_W-1:0] dac_reg;

  always_comb begin
    mix_sum = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      mix_sum = mix_sum + SUM_W'(sample[v]);
    end
    mix_sat = (mix_sum > SUM_W'(FULL_SCALE)) ? FULL_SCALE : mix_sum[DAC_W-1:0];
  end

  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      dac_reg <= '0;
    end else begin
      dac_reg <= mute ? '0 : mix_sat;
    end
  end

  assign dacCount = dac_reg;

endmodule

// File: tb/tb_poly_tone_gen.sv
// Directed bench for poly_tone_gen: table-driven square/invalid-trigger vectors
// plus hand-written sawtooth, retrigger, mix/saturation and reset sequences.
module tb_poly_tone_gen;

  localparam int DAC_W = 7;
  localparam int NV    = 2;
  localparam int PER_W = 9;
  localparam int DUR_W = 16;

  logic             clk = 1'b0;
  logic             nRst;
  logic [NV-1:0]    trig;
  logic [PER_W-1:0] per0, per1;
  logic [DUR_W-1:0] dur0, dur1;
  logic [NV-1:0]    wave_sel;
  logic             mute;
  logic [NV-1:0]    busy;
  logic [NV-1:0]    done;
  logic [DAC_W-1:0] dacCount;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  poly_tone_gen #(
    .DAC_W(DAC_W), .NUM_VOICES(NV), .PER_W(PER_W), .DUR_W(DUR_W)
  ) dut (
    .clk(clk),
    .nRst(nRst),
    .trig(trig),
    .period({per1, per0}),
    .duration({dur1, dur0}),
    .wave_sel(wave_sel),
    .mute(mute),
    .busy(busy),
    .done(done),
    .dacCount(dacCount)
  );

  typedef struct {
    logic [NV-1:0]    trig;
    logic [PER_W-1:0] per0;
    logic [DUR_W-1:0] dur0;
    logic [PER_W-1:0] per1;
    logic [DUR_W-1:0] dur1;
    logic [NV-1:0]    busy;
    logic [NV-1:0]    done;
    logic [DAC_W-1:0] dac;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [NV-1:0] t, int p0, int d0, int p1, int d1,
                              logic [NV-1:0] b, logic [NV-1:0] dn, int dac);
    vec_t r;
    r.trig = t;
    r.per0 = PER_W'(p0);
    r.dur0 = DUR_W'(d0);
    r.per1 = PER_W'(p1);
    r.dur1 = DUR_W'(d1);
    r.busy = b;
    r.done = dn;
    r.dac  = DAC_W'(dac);
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    nRst = 1'b1;
    trig = '0;
    mute = 1'b0;
    repeat (2) @(negedge clk);
    nRst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    nRst = 1'b1;
    trig = 2'b11;
    per0 = 9'd3;  dur0 = 16'd5;
    per1 = 9'd3;  dur1 = 16'd5;
    wave_sel = 2'b00;
    mute = 1'b0;

    // Reset held while triggers are active: nothing may start.
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_dac", int'(dacCount), 0);
    trig = '0;
    nRst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_dac", int'(dacCount), 0);
    check("idle_busy", int'(busy), 0);

    // Square voice 0 (period 3, duration 12) then invalid triggers; the
    // non-trigger cycles carry other period/duration values that must be ignored.
    tbl.push_back(mk(2'b01, 3, 12, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(2'b00, 7, 2, 0, 0, 2'b01, 2'b00, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(2'b00, 7, 2, 0, 0, 2'b01, 2'b00, 127));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(2'b00, 7, 2, 0, 0, 2'b01, 2'b00, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(2'b00, 7, 2, 0, 0, 2'b01, 2'b00, 127));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(2'b00, 7, 2, 0, 0, 2'b01, 2'b00, 0));
    tbl.push_back(mk(2'b00, 7, 2, 0, 0, 2'b00, 2'b01, 0));
    tbl.push_back(mk(2'b01, 0, 5, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(2'b10, 0, 0, 4, 0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(2'b11, 0, 0, 0, 9, 2'b00, 2'b00, 0));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0));

    do_reset();
    wave_sel = 2'b00;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      check($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].busy));
      check($sformatf("vec%0d_done", i), int'(done), int'(tbl[i].done));
      check($sformatf("vec%0d_dac", i), int'(dacCount), int'(tbl[i].dac));
      $display("[TB] vec %0d: busy=%b done=%b dac=%0d", i, busy, done, dacCount);
      trig = tbl[i].trig;
      per0 = tbl[i].per0;  dur0 = tbl[i].dur0;
      per1 = tbl[i].per1;  dur1 = tbl[i].dur1;
    end
    trig = '0;

    // Sawtooth voice 1, one step per clock; inputs change after trigger.
    do_reset();
    trig = 2'b10; per1 = 9'd1; dur1 = 16'd200; wave_sel = 2'b10;
    for (int k = 1; k <= 201; k++) begin
      @(negedge clk);
      trig = '0; per1 = 9'd5; dur1 = 16'd3; wave_sel = 2'b00;
      if (k >= 2 && k <= 140) check($sformatf("saw_c%0d", k), int'(dacCount), (k - 2) % 128);
      if (k == 200) check("saw_busy_end", int'(busy), 2);
      if (k == 201) begin
        check("saw_done", int'(done), 2);
        check("saw_busy_off", int'(busy), 0);
      end
    end
    $display("[TB] sawtooth sequence complete");

    // Retrigger voice 0: invalid retriggers ignored, valid one at cycle 5.
    do_reset();
    trig = 2'b01; per0 = 9'd3; dur0 = 16'd10; wave_sel = 2'b00;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      trig = '0;
      check($sformatf("retrig_busy_c%0d", k), int'(busy[0]), (k <= 9) ? 1 : 0);
      check($sformatf("retrig_done_c%0d", k), int'(done[0]), (k == 10) ? 1 : 0);
      if (k >= 7 && k <= 9) check($sformatf("retrig_dac_c%0d", k), int'(dacCount), 127);
      if (k == 10) check("retrig_dac_c10", int'(dacCount), 0);
      if (k == 2) begin trig = 2'b01; per0 = 9'd0; dur0 = 16'd10; end
      if (k == 3) begin trig = 2'b01; per0 = 9'd3; dur0 = 16'd0; end
      if (k == 5) begin trig = 2'b01; per0 = 9'd3; dur0 = 16'd4; end
    end
    $display("[TB] retrigger sequence complete");

    // Mix: square period 100 on voice 0, sawtooth period 1 on voice 1.
    do_reset();
    trig = 2'b11; per0 = 9'd100; dur0 = 16'd1000; per1 = 9'd1; dur1 = 16'd1000;
    wave_sel = 2'b10;
    for (int k = 1; k <= 182; k++) begin
      @(negedge clk);
      trig = '0;
      if (k == 52) check("mix_saturated", int'(dacCount), 127);
      if (k == 102) check("mix_low_100", int'(dacCount), 100);
      if (k == 180) begin
        check("mix_low_50", int'(dacCount), 50);
        mute = 1'b1;
      end
      if (k == 181) begin
        check("mute_dac", int'(dacCount), 0);
        check("mute_busy", int'(busy), 3);
        mute = 1'b0;
      end
      if (k == 182) check("unmute_dac", int'(dacCount), 52);
    end
    $display("[TB] mix/mute sequence complete");

    // Reset mid-note: immediate idle and no done pulse afterwards.
    nRst = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_dac", int'(dacCount), 0);
    check("midrst_done", int'(done), 0);
    @(negedge clk);
    nRst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("postrst_done_%0d", k), int'(done), 0);
      check($sformatf("postrst_busy_%0d", k), int'(busy), 0);
    end
    $display("[TB] reset-abort sequence complete");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/poly_tone_gen.md
Name: poly_tone_gen

Overview:
Parametrised successor to the single-tone game sound generator. Provides NUM_VOICES independent tone voices, each with its own period, duration and waveform (square or sawtooth). Voices are triggered by one-cycle game-event pulses (collisions, button presses), mixed with saturation and presented as a registered DAC code. Sits between the game event logic and the DAC counter/PWM output stage.

Parameters:
DAC_W, 7, width of dacCount and of each voice sample
NUM_VOICES, 2, number of independent voices (1..8)
PER_W, 9, width of per-voice period (clocks per waveform step)
DUR_W, 16, width of per-voice duration (clocks of playback)

Ports:
clk  input  1  system clock, all state on rising edge
nRst  input  1  reset; asynchronous, active-high (1 = reset)
trig  input  NUM_VOICES  per-voice start pulse, bit v = voice v
period  input  NUM_VOICES*PER_W  per-voice step period, voice v at [v*PER_W +: PER_W], sampled on trigger
duration  input  NUM_VOICES*DUR_W  per-voice play length in clocks, [v*DUR_W +: DUR_W], sampled on trigger
wave_sel  input  NUM_VOICES  per-voice waveform, 0 = square, 1 = sawtooth, sampled on trigger
mute  input  1  forces dacCount to 0; voices keep running
busy  output  NUM_VOICES  voice v is in PLAY
done  output  NUM_VOICES  one-cycle pulse when voice v finishes its duration naturally
dacCount  output  DAC_W  registered mixed sample

Behaviour:
- Reset (nRst=1, async): all voices IDLE; busy=0, done=0, dacCount=0; phase, remaining, level and ramp registers all 0.
- Per-voice FSM, states IDLE and PLAY:
  - IDLE, trig[v]=1, period!=0, duration!=0: on that edge latch period, duration and wave_sel. Load phase=0, remaining=duration, level=1, ramp=0. Enter PLAY.
  - IDLE, trig[v]=1 with period==0 or duration==0: ignored; stay IDLE, no done.
  - PLAY, trig[v]=1 with valid period and duration: retrigger. Reload exactly as from IDLE, stay PLAY, no done pulse. Invalid retrigger is ignored; the current note continues.
  - PLAY, no valid trig, remaining==1: enter IDLE; done[v]=1 on the following cycle only.
  - PLAY, otherwise: remaining decrements by 1.
  - Result: busy is high for exactly duration cycles per note.
- Phase/tick, in PLAY only:
  - If phase==period_latched-1: phase wraps to 0 and tick is asserted. Otherwise phase increments by 1.
  - period=1 gives a tick every cycle.
  - Square: level toggles on tick.
  - Sawtooth: ramp increments by 1 on tick and wraps from 2^DAC_W-1 to 0.
- Voice sample, combinational from voice registers:
  - IDLE: 0.
  - PLAY square: level ? 2^DAC_W-1 : 0.
  - PLAY sawtooth: ramp.
- Mixer:
  - Sum of all voice samples in a DAC_W+$clog2(NUM_VOICES)+1 bit accumulator.
  - Saturate to 2^DAC_W-1.
  - dacCount registered: dacCount <= mute ? 0 : sat(sum). This is one cycle of latency after voice state.
- Simultaneous triggers on several voices are independent; there is no arbitration.
- done and busy are registered outputs.
- Asserting reset mid-note aborts all voices immediately, with no done pulse.

Test Plan:
- Reset: nRst=1 with trig active -> busy=0, done=0, dacCount=0. After release, idle voices keep dacCount=0.
- Square, voice 0: period=3, duration=12, wave_sel=0, trig pulse at cycle 0 -> busy[0] high cycles 1..12. dacCount is 127 for three cycles, then 0 for three cycles, repeating. done[0] pulses at cycle 13. dacCount=0 from cycle 14.
- Sawtooth, voice 1: period=1, duration=200 -> dacCount steps 0,1,2,...,127,0,1,... one step per clock, wrapping at 127.
- Saturation/mix: voice 0 square period=100 (level high) and voice 1 sawtooth ramp at 50, both playing -> dacCount=127 (saturated). Voice 0 low -> dacCount=50. mute=1 -> dacCount=0 next cycle while busy stays 11.
- Retrigger: voice 0 duration=10, retrigger at cycle 5 with duration=4 -> busy stays high continuously and ends after cycle 9. No done at the original end. Single done pulse at cycle 10. Phase restarts at 0 and square level is high.
- Invalid triggers: period=0 or duration=0 while IDLE -> busy stays 0, no done. Same while PLAY -> current note unaffected. Reset asserted mid-note -> immediate idle, no done.
